// File: rtl/proc_pkg.sv
// proc_pkg: shared types and IR field helpers for the parametrised processor core
//   opcode_t  : 3-bit instruction opcode
//   tstep_t   : control step T0..T3
//   alu_op_t  : ALU function, encoded so it equals the low two opcode bits of the ALU ops
//   bus_sel_t : bus source select
//   get_op/get_rx/get_ry : IR field extraction for a given register-index width
package proc_pkg;
   typedef enum logic [2:0] {
      OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MVNZ, OP_NOP
   } opcode_t;
   typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;
   // add=010, sub=011, and=100, or=101: the low two opcode bits select the ALU function
   typedef enum logic [1:0] {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB} alu_op_t;
   typedef enum logic [1:0] {BUS_NONE, BUS_REG, BUS_DIN, BUS_G} bus_sel_t;
   function automatic logic [2:0] get_op(input logic [31:0] ir, input int reg_w);
      return ir[2*reg_w +: 3];
   endfunction
   function automatic logic [31:0] get_rx(input logic [31:0] ir, input int reg_w);
      return (ir >> reg_w) & ((32'd1 << reg_w) - 32'd1);
   endfunction
   function automatic logic [31:0] get_ry(input logic [31:0] ir, input int reg_w);
      return ir & ((32'd1 << reg_w) - 32'd1);
   endfunction
endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational ALU for the processor core
//   a, b    : operands (a = accumulator, b = bus)
//   alu_op  : function select
//   result  : a op b modulo 2^DATA_W
//   carry   : carry out for add, borrow (a<b) for sub, 0 for and/or
//   zero    : result is zero
module proc_alu
   import proc_pkg::*;
#(
   parameter int DATA_W = 9
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_t           alu_op,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);
   logic [DATA_W:0] sum, diff;
   assign sum  = {1'b0, a} + {1'b0, b};
   // the extra MSB of a widened subtraction is the unsigned borrow
   assign diff = {1'b0, a} - {1'b0, b};
   always_comb begin
      {carry, result} = alu_op == ALU_ADD ? sum :
                        alu_op == ALU_SUB ? diff :
                        alu_op == ALU_AND ? {1'b0, a & b} : {1'b0, a | b};
   end
   assign zero = result == '0;
endmodule

// File: rtl/proc_param_core.sv
// proc_param_core: multi-cycle bus-based processor core with register file, A, G and {C,Z} flags
//   Clock, Resetn : clock and asynchronous active-low reset
//   Run, DIN      : start request (sampled in T0) and instruction/immediate input
//   Done          : high during the final step of an instruction
//   BusWires      : internal bus value
//   R_out, RA_out, RG_out, IR_out, Flags_out, Tstep_state : debug views of internal state
module proc_param_core
   import proc_pkg::*;
#(
   parameter int DATA_W   = 9,
   parameter int NUM_REGS = 8
) (
   input  logic                       Clock,
   input  logic                       Resetn,
   input  logic                       Run,
   input  logic [DATA_W-1:0]          DIN,
   output logic                       Done,
   output logic [DATA_W-1:0]          BusWires,
   output logic [NUM_REGS*DATA_W-1:0] R_out,
   output logic [DATA_W-1:0]          RA_out,
   output logic [DATA_W-1:0]          RG_out,
   output logic [DATA_W-1:0]          IR_out,
   output logic [1:0]                 Flags_out,
   output logic [1:0]                 Tstep_state
);
   localparam int REG_W = $clog2(NUM_REGS);
   tstep_t            t;
   logic [DATA_W-1:0] r [NUM_REGS];
   logic [DATA_W-1:0] a, g, ir, alu_res;
   logic              c, z, alu_c, alu_z, is_alu, wr_t1;
   opcode_t           op;
   logic [REG_W-1:0]  rx, ry, sel;
   bus_sel_t          bsel;
   assign op     = opcode_t'(get_op(32'(ir), REG_W));
   assign rx     = REG_W'(get_rx(32'(ir), REG_W));
   assign ry     = REG_W'(get_ry(32'(ir), REG_W));
   assign is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
   // single-step ops that actually write Rx in T1; mvnz only when Z is clear
   assign wr_t1  = op == OP_MV || op == OP_MVI || (op == OP_MVNZ && !z);
   always_comb begin
      bsel = t == T3 ? BUS_G :
             t == T2 ? BUS_REG :
             t == T0 ? BUS_NONE :
             op == OP_MVI ? BUS_DIN :
             (is_alu || wr_t1) ? BUS_REG : BUS_NONE;
      sel  = (t == T1 && is_alu) ? rx : ry;
      BusWires = bsel == BUS_REG ? r[sel] :
                 bsel == BUS_DIN ? DIN :
                 bsel == BUS_G   ? g : '0;
      Done = t == T3 || (t == T1 && !is_alu);
   end
   proc_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a),
      .b      (BusWires),
      .alu_op (alu_op_t'(op[1:0])),
      .result (alu_res),
      .carry  (alu_c),
      .zero   (alu_z)
   );
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         t  <= T0;
         a  <= '0;
         g  <= '0;
         ir <= '0;
         c  <= 1'b0;
         z  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
      end else begin
         case (t)
            T0: if (Run) begin
               ir <= DIN;
               t  <= T1;
            end
            T1: if (is_alu) begin
               a <= BusWires;
               t <= T2;
            end else begin
               if (wr_t1) r[rx] <= BusWires;
               t <= T0;
            end
            T2: begin
               g <= alu_res;
               c <= alu_c;
               z <= alu_z;
               t <= T3;
            end
            T3: begin
               r[rx] <= BusWires;
               t     <= T0;
            end
         endcase
      end
   end
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_rout
      assign R_out[i*DATA_W +: DATA_W] = r[i];
   end
   assign RA_out      = a;
   assign RG_out      = g;
   assign IR_out      = ir;
   assign Flags_out   = {c, z};
   assign Tstep_state = t;
endmodule

// File: tb/tb_proc_param_core.sv
// tb_proc_param_core: directed and randomized checks of proc_param_core against an instruction-level model
module tb_proc_param_core;
   localparam int DW = 9;
   localparam int NR = 8;
   localparam int MV = 0, MVI = 1, ADD = 2, SUB = 3, AND = 4, OR = 5, MVNZ = 6, NOP = 7;
   logic             Clock = 1'b0, Resetn, Run;
   logic [DW-1:0]    DIN;
   logic             Done;
   logic [DW-1:0]    BusWires, RA_out, RG_out, IR_out;
   logic [NR*DW-1:0] R_out;
   logic [1:0]       Flags_out, Tstep_state;
   logic [DW-1:0]    m_r [NR];
   logic [DW-1:0]    m_a, m_g;
   logic             m_c, m_z;
   int               checks = 0, errors = 0;
   proc_param_core #(.DATA_W(DW), .NUM_REGS(NR)) dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Done(Done),
      .BusWires(BusWires), .R_out(R_out), .RA_out(RA_out), .RG_out(RG_out),
      .IR_out(IR_out), .Flags_out(Flags_out), .Tstep_state(Tstep_state)
   );
   always #5 Clock = ~Clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_r[i] = '0;
      m_a = '0; m_g = '0; m_c = 1'b0; m_z = 1'b0;
   endtask
   task automatic check_state(input string tag);
      for (int i = 0; i < NR; i++) chk($sformatf("%s R%0d", tag, i), 32'(R_out[i*DW +: DW]), 32'(m_r[i]));
      chk({tag, " RA"}, 32'(RA_out), 32'(m_a));
      chk({tag, " RG"}, 32'(RG_out), 32'(m_g));
      chk({tag, " flags"}, 32'(Flags_out), 32'({m_c, m_z}));
      chk({tag, " tstep"}, 32'(Tstep_state), 0);
      chk({tag, " done"}, 32'(Done), 0);
      chk({tag, " bus"}, 32'(BusWires), 0);
   endtask
   // Entered at a falling edge in T0; returns at the falling edge of the following T0.
   task automatic exec(input int op, input int rx, input int ry, input logic [DW-1:0] imm);
      logic [DW-1:0] ir, bexp;
      bit alu;
      int full, m;
      m   = 1 << DW;
      ir  = {3'(op), 3'(rx), 3'(ry)};
      alu = op >= ADD && op <= OR;
      check_state($sformatf("pre op%0d", op));
      Run = 1'b1;
      DIN = ir;
      @(negedge Clock);
      Run = 1'($urandom);
      DIN = (op == MVI) ? imm : DW'($urandom);
      #1;
      bexp = alu ? m_r[rx] : op == MV ? m_r[ry] : op == MVI ? imm :
             op == MVNZ ? (m_z ? '0 : m_r[ry]) : '0;
      chk("t1 tstep", 32'(Tstep_state), 1);
      chk("t1 done", 32'(Done), 32'(!alu));
      chk("t1 bus", 32'(BusWires), 32'(bexp));
      if (alu) begin
         m_a = m_r[rx];
         @(negedge Clock);
         Run = 1'($urandom);
         DIN = DW'($urandom);
         #1;
         chk("t2 tstep", 32'(Tstep_state), 2);
         chk("t2 done", 32'(Done), 0);
         chk("t2 bus", 32'(BusWires), 32'(m_r[ry]));
         case (op)
            ADD: begin full = int'(m_a) + int'(m_r[ry]); m_c = full >= m; end
            SUB: begin full = int'(m_a) - int'(m_r[ry]) + m; m_c = m_a < m_r[ry]; end
            AND: begin full = int'(m_a & m_r[ry]); m_c = 1'b0; end
            default: begin full = int'(m_a | m_r[ry]); m_c = 1'b0; end
         endcase
         m_g = DW'(full % m);
         m_z = m_g == 0;
         @(negedge Clock);
         Run = 1'($urandom);
         #1;
         chk("t3 tstep", 32'(Tstep_state), 3);
         chk("t3 done", 32'(Done), 1);
         chk("t3 bus", 32'(BusWires), 32'(m_g));
         m_r[rx] = m_g;
      end else if (op == MV || op == MVI || (op == MVNZ && !m_z)) begin
         m_r[rx] = bexp;
      end
      @(negedge Clock);
   endtask
   task automatic idle(input int n);
      Run = 1'b0;
      repeat (n) begin
         @(negedge Clock);
         chk("idle tstep", 32'(Tstep_state), 0);
      end
   endtask
   initial begin
      Resetn = 1'b0;
      Run    = 1'b0;
      DIN    = '0;
      model_reset();
      repeat (2) @(negedge Clock);
      check_state("reset");
      chk("reset IR", 32'(IR_out), 0);
      Resetn = 1'b1;
      @(negedge Clock);
      exec(MVI, 0, 0, 9'd5);
      exec(MVI, 1, 0, 9'd3);
      exec(ADD, 0, 1, 0);
      check_state("add 5+3");
      exec(MVI, 0, 0, 9'd511);
      exec(MVI, 1, 0, 9'd1);
      exec(ADD, 0, 1, 0);
      exec(MVI, 2, 0, 9'd7);
      exec(SUB, 2, 2, 0);
      exec(MVI, 3, 0, 9'd4);
      exec(MVI, 0, 0, 9'd9);
      exec(SUB, 2, 2, 0);
      exec(MVNZ, 3, 0, 0);
      exec(ADD, 0, 1, 0);
      exec(MVNZ, 3, 0, 0);
      exec(NOP, 5, 6, 0);
      exec(ADD, 4, 4, 0);
      exec(MVI, 4, 0, 9'd300);
      exec(ADD, 4, 4, 0);
      idle(2);
      // reset in T2 of an add, between clock edges
      Run = 1'b1;
      DIN = {3'(ADD), 3'd0, 3'd1};
      @(negedge Clock);
      Run = 1'b0;
      @(negedge Clock);
      chk("pre-reset tstep", 32'(Tstep_state), 2);
      #2 Resetn = 1'b0;
      #1;
      model_reset();
      chk("async reset IR", 32'(IR_out), 0);
      check_state("async reset");
      #1 Resetn = 1'b1;
      @(negedge Clock);
      check_state("after reset");
      exec(MVI, 2, 0, 9'd8);
      exec(MVI, 1, 0, 9'd7);
      exec(OR, 1, 2, 0);
      check_state("or 7|8");
      for (int k = 0; k < 300; k++) begin
         exec(int'($urandom_range(0, 7)), int'($urandom_range(0, NR - 1)),
              int'($urandom_range(0, NR - 1)), DW'($urandom));
         if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      end
      check_state("final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
